// File: rtl/usr_param.sv
// Parametrised universal shift register with clock enable and frame counter.
// Optional registered parity output when USR_PARITY_EN is defined.
module usr_param #(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 4
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         en,
  input  logic [2:0]                   sel,
  input  logic                         si_r,
  input  logic                         si_l,
  input  logic [WIDTH-1:0]             pi,
  output logic [WIDTH-1:0]             po,
  output logic                         so_r,
  output logic                         so_l,
  output logic [$clog2(FRAME_LEN)-1:0] shift_cnt,
  output logic                         frame_done
`ifdef USR_PARITY_EN
  ,
  output logic                         parity
`endif
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  logic [WIDTH-1:0] po_nxt;
  logic             is_shift;
  logic             is_load;

  assign so_r = po[0];
  assign so_l = po[WIDTH-1];

  always_comb begin
    po_nxt   = po;
    is_shift = 1'b0;
    is_load  = 1'b0;
    if (en) begin
      unique case (sel)
        3'b001: begin
          po_nxt   = {si_r, po[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        3'b010: begin
          po_nxt   = {po[WIDTH-2:0], si_l};
          is_shift = 1'b1;
        end
        3'b011: begin
          po_nxt  = pi;
          is_load = 1'b1;
        end
        3'b100: begin
          po_nxt   = {po[0], po[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        3'b101: begin
          po_nxt   = {po[WIDTH-2:0], po[WIDTH-1]};
          is_shift = 1'b1;
        end
        3'b110: begin
          po_nxt   = {po[WIDTH-1], po[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        default: po_nxt = po;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      po         <= '0;
      shift_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      po         <= po_nxt;
      frame_done <= 1'b0;
      if (is_load) begin
        shift_cnt <= '0;
      end else if (is_shift) begin
        // wrap explicitly so non-power-of-2 frames never overrun
        if (shift_cnt == LAST) begin
          shift_cnt  <= '0;
          frame_done <= 1'b1;
        end else begin
          shift_cnt <= shift_cnt + CW'(1);
        end
      end
    end
  end

`ifdef USR_PARITY_EN
  always_ff @(posedge clk) begin
    if (!clr) parity <= 1'b0;
    else      parity <= ^po_nxt;
  end
`endif

endmodule

// File: tb/tb_usr_param.sv
// Directed self-checking bench for usr_param (WIDTH=4, FRAME_LEN=4).
// Define USR_PARITY_EN to also exercise the parity output.
module tb_usr_param;

  logic       clk = 1'b0;
  logic       clr;
  logic       en;
  logic [2:0] sel;
  logic       si_r;
  logic       si_l;
  logic [3:0] pi;
  logic [3:0] po;
  logic       so_r;
  logic       so_l;
  logic [1:0] shift_cnt;
  logic       frame_done;
`ifdef USR_PARITY_EN
  logic       parity;
`endif

  int checks = 0;
  int errors = 0;

  usr_param #(.WIDTH(4), .FRAME_LEN(4)) dut (
    .clk        (clk),
    .clr        (clr),
    .en         (en),
    .sel        (sel),
    .si_r       (si_r),
    .si_l       (si_l),
    .pi         (pi),
    .po         (po),
    .so_r       (so_r),
    .so_l       (so_l),
    .shift_cnt  (shift_cnt),
    .frame_done (frame_done)
`ifdef USR_PARITY_EN
    ,
    .parity     (parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [3:0] e_po,
                        input logic [1:0] e_cnt, input logic e_fd);
    chk({tag, ".po"}, 32'(po), 32'(e_po));
    chk({tag, ".cnt"}, 32'(shift_cnt), 32'(e_cnt));
    chk({tag, ".fd"}, 32'(frame_done), 32'(e_fd));
  endtask

  initial begin
    clr  = 1'b0;
    en   = 1'b1;
    si_r = 1'b0;
    si_l = 1'b0;
    sel  = 3'($urandom_range(7));
    pi   = 4'($urandom);
    cyc();
    sel  = 3'($urandom_range(7));
    pi   = 4'($urandom);
    cyc();
    chk_st("reset", 4'b0000, 2'd0, 1'b0);
    chk("reset.so_r", 32'(so_r), 32'd0);
    chk("reset.so_l", 32'(so_l), 32'd0);

    clr = 1'b1;
    sel = 3'b011; pi = 4'b1101;
    cyc(); chk_st("load1", 4'b1101, 2'd0, 1'b0);
    sel = 3'b001;
    si_r = 1'b1; cyc(); chk_st("sr1", 4'b1110, 2'd1, 1'b0);
    si_r = 1'b1; cyc(); chk_st("sr2", 4'b1111, 2'd2, 1'b0);
    si_r = 1'b0; cyc(); chk_st("sr3", 4'b0111, 2'd3, 1'b0);
    si_r = 1'b1; cyc(); chk_st("sr4", 4'b1011, 2'd0, 1'b1);
    sel = 3'b000;
    cyc(); chk_st("hold", 4'b1011, 2'd0, 1'b0);

    sel = 3'b011; pi = 4'b1101;
    cyc(); chk_st("load2", 4'b1101, 2'd0, 1'b0);
    chk("sl.so_l0", 32'(so_l), 32'd1);
    sel = 3'b010; si_l = 1'b0;
    cyc(); chk_st("sl1", 4'b1010, 2'd1, 1'b0);
    chk("sl.so_l1", 32'(so_l), 32'd1);
    cyc(); chk_st("sl2", 4'b0100, 2'd2, 1'b0);
    chk("sl.so_l2", 32'(so_l), 32'd0);

    sel = 3'b011; pi = 4'b1101;
    cyc(); chk_st("load_abort", 4'b1101, 2'd0, 1'b0);
    sel = 3'b100;
    cyc(); chk_st("rotr", 4'b1110, 2'd1, 1'b0);
    sel = 3'b101;
    cyc(); chk_st("rotl", 4'b1101, 2'd2, 1'b0);
    sel = 3'b011; pi = 4'b1001;
    cyc(); chk_st("load3", 4'b1001, 2'd0, 1'b0);
    chk("load3.so_r", 32'(so_r), 32'd1);
    sel = 3'b110;
    cyc(); chk_st("asr", 4'b1100, 2'd1, 1'b0);
    chk("asr.so_r", 32'(so_r), 32'd0);

    sel = 3'b011; pi = 4'b0000;
    cyc();
    sel = 3'b001; si_r = 1'b0;
    cyc(); cyc(); chk_st("pre_clr", 4'b0000, 2'd2, 1'b0);
    clr = 1'b0;
    cyc(); chk_st("mid_clr", 4'b0000, 2'd0, 1'b0);
    clr = 1'b1; si_r = 1'b1;
    cyc(); chk_st("pc1", 4'b1000, 2'd1, 1'b0);
    cyc(); chk_st("pc2", 4'b1100, 2'd2, 1'b0);
    cyc(); chk_st("pc3", 4'b1110, 2'd3, 1'b0);
    cyc(); chk_st("pc4", 4'b1111, 2'd0, 1'b1);
    si_r = 1'b0;
    cyc(); chk_st("pc5", 4'b0111, 2'd1, 1'b0);
    sel = 3'b111;
    cyc(); chk_st("rsvd", 4'b0111, 2'd1, 1'b0);

    en = 1'b0; sel = 3'b001; si_r = 1'b1;
    cyc(); chk_st("en0_1", 4'b0111, 2'd1, 1'b0);
    cyc(); chk_st("en0_2", 4'b0111, 2'd1, 1'b0);
    cyc(); chk_st("en0_3", 4'b0111, 2'd1, 1'b0);

`ifdef USR_PARITY_EN
    en = 1'b1; sel = 3'b011; pi = 4'b1101;
    cyc(); chk("parity_1101", 32'(parity), 32'd1);
    pi = 4'b1001;
    cyc(); chk("parity_1001", 32'(parity), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
